// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream reader.
package async_fifo_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned LEN_WIDTH_DEF  = 16;
   localparam int unsigned SKID_DEPTH     = 2;
   localparam int unsigned SKID_CNT_W     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } rd_state_e;

endpackage

// File: rtl/async_fifo_stream_reader_if.sv
// Control, FIFO read port and output stream of the stream reader.
interface async_fifo_stream_reader_if
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
);

   logic                  start;
   logic [LEN_WIDTH-1:0]  xfer_len;
   logic                  busy;
   logic                  done;
   logic [LEN_WIDTH-1:0]  words_left;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   // Reader side
   modport master (
      input  start, xfer_len, fifo_rd_data, fifo_empty, out_ready,
      output busy, done, words_left, fifo_rd_en, out_valid, out_data, out_last
   );

   // Environment side: FIFO, controller and downstream sink
   modport slave (
      output start, xfer_len, fifo_rd_data, fifo_empty, out_ready,
      input  busy, done, words_left, fifo_rd_en, out_valid, out_data, out_last
   );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid FIFO absorbing the registered FIFO read latency.
module fifo_rd_skid
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic [SKID_CNT_W-1:0] count
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [SKID_CNT_W-1:0] count_q;
   logic                  do_push;
   logic                  do_pop;

   // Guarded so a misbehaving producer cannot corrupt the pointers
   assign do_pop  = pop & (count_q != '0);
   assign do_push = push & ((count_q != SKID_CNT_W'(SKID_DEPTH)) | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(SKID_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + SKID_CNT_W'(do_push) - SKID_CNT_W'(do_pop);
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/async_fifo_stream_reader.sv
// Read-domain consumer: pops xfer_len words from the async FIFO and re-emits
// them on a valid/ready stream, flagging the last word.
module async_fifo_stream_reader
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                              rd_clk,
   input  logic                              rd_rst_n,
   async_fifo_stream_reader_if.master        rd_if
);

   rd_state_e             state_q;
   rd_state_e             state_d;
   logic [LEN_WIDTH-1:0]  issue_left_q;
   logic [LEN_WIDTH-1:0]  words_left_q;
   logic                  inflight_q;
   logic [SKID_CNT_W-1:0] skid_count;
   logic [DATA_WIDTH-1:0] skid_head;
   logic                  valid_c;
   logic                  hs_c;
   logic [2:0]            room_c;
   logic                  busy_c;
   logic                  done_c;
   logic                  rd_en_c;
   logic                  load_c;

   assign valid_c = (skid_count != '0);
   assign hs_c    = valid_c & rd_if.out_ready;
   // Free skid slots next cycle, counting the word in flight from the FIFO
   assign room_c  = 3'(SKID_DEPTH) - 3'(skid_count) - 3'(inflight_q) + 3'(hs_c);
   assign load_c  = (state_q == IDLE) & rd_if.start & (rd_if.xfer_len != '0);

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (rd_if.start) state_d = (rd_if.xfer_len != '0) ? RUN : DONE;
         RUN:  if (hs_c && (words_left_q == LEN_WIDTH'(1))) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_c  = 1'b0;
      done_c  = 1'b0;
      rd_en_c = 1'b0;
      unique case (state_q)
         RUN: begin
            busy_c  = 1'b1;
            rd_en_c = ~rd_if.fifo_empty & (issue_left_q != '0) & (room_c != 3'd0);
         end
         DONE: begin
            busy_c = 1'b1;
            done_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Issue and completion counters; both saturate at zero
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         issue_left_q <= '0;
         words_left_q <= '0;
         inflight_q   <= 1'b0;
      end else begin
         inflight_q <= rd_en_c;
         if (load_c) begin
            issue_left_q <= rd_if.xfer_len;
            words_left_q <= rd_if.xfer_len;
         end else begin
            if (rd_en_c && (issue_left_q != '0)) issue_left_q <= issue_left_q - LEN_WIDTH'(1);
            if (hs_c && (words_left_q != '0))    words_left_q <= words_left_q - LEN_WIDTH'(1);
         end
      end
   end

   fifo_rd_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (rd_clk),
      .rst_n     (rd_rst_n),
      .push      (inflight_q),
      .push_data (rd_if.fifo_rd_data),
      .pop       (hs_c),
      .head_data (skid_head),
      .count     (skid_count)
   );

   assign rd_if.busy       = busy_c;
   assign rd_if.done       = done_c;
   assign rd_if.fifo_rd_en = rd_en_c;
   assign rd_if.words_left = words_left_q;
   assign rd_if.out_valid  = valid_c;
   assign rd_if.out_data   = skid_head;
   assign rd_if.out_last   = valid_c & (words_left_q == LEN_WIDTH'(1));

endmodule

// File: doc/async_fifo_stream_reader.md
Name: async_fifo_stream_reader

Overview:
- Read-side consumer for the async FIFO. Runs entirely in the rd_clk domain.
- On a start pulse it pops exactly xfer_len words from the FIFO read port.
- It re-emits those words on a valid/ready output stream and flags the final word with out_last.
- It absorbs the FIFO's 1-cycle registered read latency with a 2-entry skid buffer, so sustained throughput is 1 word/cycle under continuous out_ready.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and out_data.
- LEN_WIDTH, 16, width of xfer_len and the remaining-word counters.

Ports:
- rd_clk  input  1  read-domain clock; all logic is on its rising edge.
- rd_rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle transfer request; sampled only in IDLE.
- xfer_len  input  LEN_WIDTH  number of words to transfer; sampled with start.
- busy  output  1  high while a transfer is in progress.
- done  output  1  1-cycle pulse when a transfer completes.
- words_left  output  LEN_WIDTH  words not yet handshaken on the output.
- fifo_rd_en  output  1  FIFO pop request.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after a pop.
- fifo_empty  input  1  FIFO empty flag.
- out_valid  output  1  output stream valid.
- out_ready  input  1  output stream ready.
- out_data  output  DATA_WIDTH  output stream data.
- out_last  output  1  marks the final word of the transfer.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; issue_left=0, words_left=0, skid_count=0, inflight=0.
  - busy, done, fifo_rd_en, out_valid and out_last are all 0; out_data is 0.
- States:
  - IDLE: start=1 and xfer_len>0 -> RUN; load issue_left and words_left from xfer_len.
  - IDLE: start=1 and xfer_len=0 -> DONE; no pop is issued.
  - RUN: the handshake that takes words_left from 1 to 0 -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
- busy = (state != IDLE). start is ignored while busy.
- fifo_rd_en is combinational and asserts only when all of the following hold:
  - state is RUN;
  - fifo_empty is 0;
  - issue_left > 0;
  - 2 - skid_count - inflight + pop > 0, where pop = out_valid & out_ready.
- The block never pops an empty FIFO and never pops more than xfer_len words.
- Each pop decrements issue_left and sets inflight=1.
- The cycle after a pop, fifo_rd_data is written into the skid FIFO and inflight clears.
- Latency:
  - fifo_rd_en high in cycle N -> word enters the skid at the end of cycle N+1 -> out_valid=1 in cycle N+2.
  - start in cycle 0 with a non-empty FIFO -> fifo_rd_en in cycle 1 -> first out_valid in cycle 3.
- Output stream:
  - out_valid = (skid_count > 0); out_data is the skid head.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
  - out_last = out_valid & (words_left == 1).
- Each handshake pops the skid head and decrements words_left.
- A simultaneous skid write and pop leaves skid_count unchanged.
- Skid overflow is impossible by construction. The bench asserts skid_count + inflight <= 2 on every cycle.
- fifo_empty rising mid-transfer stalls pops only; already-buffered words continue to drain.
- Reset mid-transfer: all state clears immediately and any in-flight word is discarded. The FIFO is reset in the same event.
- Counters are LEN_WIDTH wide, never wrap, and do not decrement below 0.

Decomposition:
- Shared package async_fifo_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - SKID_DEPTH=2;
  - the default DATA_WIDTH and LEN_WIDTH constants.
- One sub-module, fifo_rd_skid: a 2-entry synchronous FIFO with push, pop, head data and count.
- The top level holds the FSM, the counters and the issue logic.

Test Plan:
- FIFO preloaded with 0..9, xfer_len=10, out_ready=1 -> out_data 0..9 on consecutive cycles from cycle 3. out_last only on 9. done pulses once, the cycle after word 9. Exactly 10 fifo_rd_en cycles.
- FIFO preloaded with 80 words, xfer_len=80, out_ready toggling 1/0 -> in-order 0..79, no duplicates or drops. out_data stable while stalled. skid_count+inflight <= 2 always.
- xfer_len=0 -> done in cycle 1, fifo_rd_en never asserts, busy high for 1 cycle.
- FIFO empty at start, xfer_len=5, writer supplies 5 words spread over ~200 ns -> no pop while fifo_empty=1. All 5 words delivered in order and out_last on the 5th. A second start pulse during the transfer is ignored.
- FIFO holds 64 words, xfer_len=20 -> exactly 20 pops and words_left reaches 0. 44 words remain, and a following xfer_len=44 returns words 20..63.
- rd_rst_n pulled low mid-transfer after 3 of 10 words -> busy, out_valid, fifo_rd_en, done and words_left all 0 immediately. After release, start with xfer_len=4 and fresh data 0xAA..0xAD -> 0xAA..0xAD delivered correctly.
